// File: rtl/note_arbiter_if.sv
// Note-source / tone-output bundle between the piano note sources and the arbiter.
interface note_arbiter_if;
  logic [2:0] req;
  logic [3:0] note_l;
  logic [3:0] note_a1;
  logic [3:0] note_a2;
  logic [2:0] grant;
  logic [3:0] note_out;
  logic       gate;
  logic       busy;

  modport master (
    output req, note_l, note_a1, note_a2,
    input  grant, note_out, gate, busy
  );

  modport slave (
    input  req, note_l, note_a1, note_a2,
    output grant, note_out, gate, busy
  );
endinterface

// File: rtl/note_arbiter.sv
// Grants the single tone output to lesson / auto1 / auto2 with a minimum note hold
// and a silent articulation gap between consecutive notes.
module note_arbiter #(
  parameter int unsigned MIN_HOLD = 5_000_000,
  parameter int unsigned GAP_CYC  = 1_000_000,
  parameter int unsigned CNT_W    = 23
) (
  input  logic           CLK,
  input  logic           RESET,
  note_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SUSTAIN,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rr, w_rr_nxt;
  logic [3:0]       r_own_note, w_own_note_nxt;
  logic [2:0]       r_grant, w_grant_nxt;
  logic [3:0]       r_note_out, w_note_out_nxt;
  logic             r_gate, w_gate_nxt;
  logic             r_busy, w_busy_nxt;

  logic [2:0]       w_valid;
  logic [2:0]       w_pick;
  logic [3:0]       w_pick_note;
  logic             w_owner_valid;
  logic [3:0]       w_owner_note;
  logic             w_release;
  logic             w_start;
  logic             w_to_gap;

  // A request carrying a rest code counts as no request.
  assign w_valid[0] = bus.req[0] && (bus.note_l  != 4'd0) && (bus.note_l  <= 4'd8);
  assign w_valid[1] = bus.req[1] && (bus.note_a1 != 4'd0) && (bus.note_a1 <= 4'd8);
  assign w_valid[2] = bus.req[2] && (bus.note_a2 != 4'd0) && (bus.note_a2 <= 4'd8);

  // Lesson first; the two autos alternate through r_rr (0 = auto1 preferred).
  always_comb begin
    w_pick      = 3'b000;
    w_pick_note = 4'd0;
    if (w_valid[0]) begin
      w_pick = 3'b001;
    end else if (w_valid[1] && w_valid[2]) begin
      w_pick = r_rr ? 3'b100 : 3'b010;
    end else if (w_valid[1]) begin
      w_pick = 3'b010;
    end else if (w_valid[2]) begin
      w_pick = 3'b100;
    end
    if (w_pick[0]) w_pick_note = bus.note_l;
    if (w_pick[1]) w_pick_note = bus.note_a1;
    if (w_pick[2]) w_pick_note = bus.note_a2;
  end

  // Current owner's live request, used to decide when the held note must end.
  always_comb begin
    w_owner_note = 4'd0;
    if (r_grant[0]) w_owner_note = bus.note_l;
    if (r_grant[1]) w_owner_note = bus.note_a1;
    if (r_grant[2]) w_owner_note = bus.note_a2;
  end

  assign w_owner_valid = |(r_grant & w_valid);
  assign w_release     = !w_owner_valid
                       || (w_owner_note != r_own_note)
                       || (w_valid[0] && !r_grant[0]);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rr_nxt       = r_rr;
    w_own_note_nxt = r_own_note;
    w_grant_nxt    = r_grant;
    w_note_out_nxt = r_note_out;
    w_gate_nxt     = r_gate;
    w_busy_nxt     = r_busy;
    w_start        = 1'b0;
    w_to_gap       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|w_valid) w_start = 1'b1;
      end
      S_HOLD: begin
        // The sustain decision is taken on the last hold cycle so the note sounds exactly MIN_HOLD.
        if (r_cnt == HOLD_LAST) begin
          if (w_release) begin
            w_to_gap = 1'b1;
          end else begin
            w_state_nxt = S_SUSTAIN;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_SUSTAIN: begin
        if (w_release) w_to_gap = 1'b1;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          if (|w_valid) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_grant_nxt = 3'b000;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_cnt_nxt      = '0;
        w_grant_nxt    = 3'b000;
        w_note_out_nxt = 4'd0;
        w_gate_nxt     = 1'b0;
      end
    endcase

    if (w_start) begin
      w_state_nxt    = S_HOLD;
      w_cnt_nxt      = '0;
      w_grant_nxt    = w_pick;
      w_own_note_nxt = w_pick_note;
      w_note_out_nxt = w_pick_note;
      w_gate_nxt     = 1'b1;
      if (w_pick[1]) w_rr_nxt = 1'b1;
      if (w_pick[2]) w_rr_nxt = 1'b0;
    end

    // Grant stays with the outgoing owner through the gap.
    if (w_to_gap) begin
      w_state_nxt    = S_GAP;
      w_cnt_nxt      = '0;
      w_note_out_nxt = 4'd0;
      w_gate_nxt     = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rr       <= 1'b0;
      r_own_note <= 4'd0;
      r_grant    <= 3'b000;
      r_note_out <= 4'd0;
      r_gate     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rr       <= w_rr_nxt;
      r_own_note <= w_own_note_nxt;
      r_grant    <= w_grant_nxt;
      r_note_out <= w_note_out_nxt;
      r_gate     <= w_gate_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.note_out = r_note_out;
  assign bus.gate     = r_gate;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_note_arbiter.sv
// Directed and random checks of note_arbiter against a timestamp-based reference model.
module tb_note_arbiter;
  localparam int MIN_HOLD = 8;
  localparam int GAP_CYC  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Reference model: owner, its note, and the cycle at which its sound / gap began.
  int m_owner;
  int m_note;
  int m_start;
  int m_gap_start;
  bit m_in_gap;
  int m_rr;
  int now;

  note_arbiter_if bus ();

  note_arbiter #(.MIN_HOLD(MIN_HOLD), .GAP_CYC(GAP_CYC), .CNT_W(4)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int note_of(int s);
    case (s)
      0:       return int'(bus.note_l);
      1:       return int'(bus.note_a1);
      default: return int'(bus.note_a2);
    endcase
  endfunction

  function automatic bit valid_of(int s);
    int n;
    n = note_of(s);
    return bus.req[s] && (n >= 1) && (n <= 8);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask

  // Pick a winner from current inputs; returns 1 if a note started.
  task automatic model_pick(output bit started);
    int w;
    w = -1;
    if (valid_of(0)) w = 0;
    else if (valid_of(1) && valid_of(2)) w = (m_rr == 0) ? 1 : 2;
    else if (valid_of(1)) w = 1;
    else if (valid_of(2)) w = 2;
    started = (w >= 0);
    if (started) begin
      m_owner  = w;
      m_note   = note_of(w);
      m_start  = now + 1;
      m_in_gap = 1'b0;
      if (w == 1) m_rr = 1;
      if (w == 2) m_rr = 0;
    end
  endtask

  task automatic model_step();
    bit started;
    if (!rst_n) begin
      m_owner  = -1;
      m_in_gap = 1'b0;
      m_rr     = 0;
    end else if (m_owner < 0) begin
      model_pick(started);
    end else if (!m_in_gap) begin
      if ((now - m_start + 1 >= MIN_HOLD) &&
          (!valid_of(m_owner) || note_of(m_owner) != m_note || (m_owner != 0 && valid_of(0)))) begin
        m_in_gap    = 1'b1;
        m_gap_start = now + 1;
      end
    end else if (now - m_gap_start + 1 >= GAP_CYC) begin
      model_pick(started);
      if (!started) begin
        m_owner  = -1;
        m_in_gap = 1'b0;
      end
    end
  endtask

  // One clock: advance the model on the sampled inputs, then compare just after the edge.
  task automatic tick();
    logic [3:0] eg;
    logic [3:0] en;
    logic       eb;
    logic       ea;
    model_step();
    @(posedge clk);
    #1;
    now++;
    eg = 4'd0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    ea = (m_owner >= 0) && !m_in_gap;
    en = ea ? 4'(m_note) : 4'd0;
    eb = (m_owner >= 0);
    chk("grant",    {1'b0, bus.grant}, eg);
    chk("note_out", bus.note_out,      en);
    chk("gate",     {3'b0, bus.gate},  {3'b0, ea});
    chk("busy",     {3'b0, bus.busy},  {3'b0, eb});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    now   = 0;
    m_owner = -1; m_note = 0; m_start = 0; m_gap_start = 0; m_in_gap = 1'b0; m_rr = 0;

    // Reset with all requests active
    rst_n = 1'b0;
    bus.req = 3'b111; bus.note_l = 4'd1; bus.note_a1 = 4'd2; bus.note_a2 = 4'd3;
    @(negedge clk);
    ticks(2);
    chk("rst_grant", {1'b0, bus.grant}, 4'd0);
    chk("rst_busy",  {3'b0, bus.busy},  4'd0);
    bus.req = 3'b000;
    rst_n = 1'b1;
    tick();

    // Lesson note 3, changed to 5 during hold
    bus.req = 3'b001; bus.note_l = 4'd3;
    tick();
    chk("s2_grant", {1'b0, bus.grant}, 4'b0001);
    chk("s2_note",  bus.note_out, 4'd3);
    ticks(2);
    bus.note_l = 4'd5;
    ticks(5);
    chk("s2_hold_end", bus.note_out, 4'd3);
    tick();
    chk("s2_gap_gate", {3'b0, bus.gate}, 4'd0);
    chk("s2_gap_grant", {1'b0, bus.grant}, 4'b0001);
    ticks(4);
    chk("s2_new_note", bus.note_out, 4'd5);
    chk("s2_new_gate", {3'b0, bus.gate}, 4'd1);
    bus.req = 3'b000;
    ticks(16);

    // Both autos: round robin on each re-arbitration
    bus.req = 3'b110; bus.note_a1 = 4'd2; bus.note_a2 = 4'd6;
    tick();
    chk("s3_first", {1'b0, bus.grant}, 4'b0010);
    for (int k = 0; k < 2; k++) begin
      ticks(8);
      bus.req = (k == 0) ? 3'b100 : 3'b010;
      tick();
      bus.req = 3'b110;
      ticks(4);
      chk("s3_rr", {1'b0, bus.grant}, (k == 0) ? 4'b0100 : 4'b0010);
    end
    bus.req = 3'b000;
    ticks(16);

    // Lesson preempts a sustaining auto only through a gap
    bus.req = 3'b010; bus.note_a1 = 4'd4;
    ticks(10);
    bus.req = 3'b011; bus.note_l = 4'd8;
    tick();
    chk("s4_gap", {3'b0, bus.gate}, 4'd0);
    ticks(4);
    chk("s4_grant", {1'b0, bus.grant}, 4'b0001);
    chk("s4_note",  bus.note_out, 4'd8);
    bus.req = 3'b000;
    ticks(16);

    // Short lesson tap still sounds the full hold, then idles
    bus.req = 3'b001; bus.note_l = 4'd1;
    ticks(2);
    bus.req = 3'b000;
    ticks(6);
    chk("s5_still", bus.note_out, 4'd1);
    tick();
    chk("s5_gap_busy", {3'b0, bus.busy}, 4'd1);
    ticks(4);
    chk("s5_idle_busy",  {3'b0, bus.busy},  4'd0);
    chk("s5_idle_grant", {1'b0, bus.grant}, 4'd0);

    // Reset during hold silences on the same edge
    bus.req = 3'b001; bus.note_l = 4'd2;
    ticks(2);
    rst_n = 1'b0;
    tick();
    chk("s6_gate", {3'b0, bus.gate}, 4'd0);
    chk("s6_note", bus.note_out, 4'd0);
    rst_n = 1'b1;
    bus.req = 3'b000;
    ticks(3);
    chk("s6_idle", {3'b0, bus.busy}, 4'd0);

    // Random traffic with rest codes and occasional reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) bus.note_l  = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 11) == 0) bus.note_a1 = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 11) == 0) bus.note_a2 = 4'($urandom_range(0, 10));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
